// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 800x600@72Hz (50 MHz) VGA timing defaults.
//   VGA_H_* : horizontal active/front porch/sync/back porch in pixels
//   VGA_V_* : vertical active/front porch/sync/back porch in lines
//   VGA_*_POL : default sync polarities (1 = active-high)
//   VGA_PIPE_DELAY : ROM_Addr register + ROM output register
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP = 56;
  localparam int VGA_H_SYNC = 120;
  localparam int VGA_H_BP = 64;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP = 37;
  localparam int VGA_V_SYNC = 6;
  localparam int VGA_V_BP = 23;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam bit VGA_HS_POL = 1'b1;
  localparam bit VGA_VS_POL = 1'b1;
  localparam int VGA_PIPE_DELAY = 2;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: enabled shift register, every stage reset to RST_VAL.
//   CLK, RESET_N (async, active-low), en (shift enable)
//   d : input vector, q : d delayed by DEPTH enabled cycles
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/hv_sync_generator.sv
// hv_sync_generator: raster counters plus VGA sync/blank delayed to match the ROM pixel pipeline.
//   CLK, RESET_N (async, active-low), PixEn (advance enable)
//   CounterX/CounterY : raster position; inDisplayArea : undelayed active-video flag
//   VGA_HS/VGA_VS/VGA_BLANK_N : delayed by PIPE_DELAY enabled cycles
//   VGA_SYNC_N : tied 0; FrameStart : registered pulse on the frame wrap
module hv_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int CNTR_WIDTH_H = 11,
  parameter int CNTR_WIDTH_V = 10,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter bit HS_POL = VGA_HS_POL,
  parameter bit VS_POL = VGA_VS_POL,
  parameter int PIPE_DELAY = VGA_PIPE_DELAY
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    PixEn,
  output logic [CNTR_WIDTH_H-1:0] CounterX,
  output logic [CNTR_WIDTH_V-1:0] CounterY,
  output logic                    inDisplayArea,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic                    VGA_BLANK_N,
  output logic                    VGA_SYNC_N,
  output logic                    FrameStart
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 2 ** CNTR_WIDTH_H) begin : g_h_chk
    $error("H_TOTAL does not fit in CNTR_WIDTH_H");
  end
  if (V_TOTAL > 2 ** CNTR_WIDTH_V) begin : g_v_chk
    $error("V_TOTAL does not fit in CNTR_WIDTH_V");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_d_chk
    $error("PIPE_DELAY must be 1..8");
  end
  localparam logic [CNTR_WIDTH_H-1:0] X_LAST = CNTR_WIDTH_H'(H_TOTAL - 1);
  localparam logic [CNTR_WIDTH_H-1:0] X_ACT = CNTR_WIDTH_H'(H_ACTIVE);
  localparam logic [CNTR_WIDTH_H-1:0] HS_FIRST = CNTR_WIDTH_H'(H_ACTIVE + H_FP);
  localparam logic [CNTR_WIDTH_H-1:0] HS_LAST = CNTR_WIDTH_H'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNTR_WIDTH_V-1:0] Y_LAST = CNTR_WIDTH_V'(V_TOTAL - 1);
  localparam logic [CNTR_WIDTH_V-1:0] Y_ACT = CNTR_WIDTH_V'(V_ACTIVE);
  localparam logic [CNTR_WIDTH_V-1:0] VS_FIRST = CNTR_WIDTH_V'(V_ACTIVE + V_FP);
  localparam logic [CNTR_WIDTH_V-1:0] VS_LAST = CNTR_WIDTH_V'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic x_wrap, y_wrap, hs_raw, vs_raw;
  always_comb begin
    x_wrap = CounterX == X_LAST;
    y_wrap = CounterY == Y_LAST;
    hs_raw = CounterX >= HS_FIRST && CounterX <= HS_LAST;
    vs_raw = CounterY >= VS_FIRST && CounterY <= VS_LAST;
    inDisplayArea = CounterX < X_ACT && CounterY < Y_ACT;
  end
  // FrameStart is not gated by PixEn hold: it is a one-CLK pulse, so it drops
  // on the next CLK even if PixEn stays low at (0,0).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CounterX <= '0;
      CounterY <= '0;
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= PixEn & x_wrap & y_wrap;
      if (PixEn) begin
        CounterX <= x_wrap ? '0 : CounterX + 1'b1;
        if (x_wrap) CounterY <= y_wrap ? '0 : CounterY + 1'b1;
      end
    end
  end
  // Polarity is applied before the delay so reset can preload inactive pin levels.
  sync_delay_line #(
    .WIDTH(3),
    .DEPTH(PIPE_DELAY),
    .RST_VAL({~HS_POL, ~VS_POL, 1'b0})
  ) u_dly (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .en(PixEn),
    .d({hs_raw ^ ~HS_POL, vs_raw ^ ~VS_POL, inDisplayArea}),
    .q({VGA_HS, VGA_VS, VGA_BLANK_N})
  );
  assign VGA_SYNC_N = 1'b0;
endmodule

// File: tb/tb_hv_sync_generator.sv
// tb_hv_sync_generator: randomized PixEn against a position-count reference model.
module tb_hv_sync_generator;
  logic CLK = 1'b0, RESET_N = 1'b0, PixEn = 1'b0;
  logic [10:0] ax;
  logic [9:0] ay;
  logic a_ida, a_hs, a_vs, a_bn, a_sn, a_fs;
  logic [4:0] bx, by;
  logic b_ida, b_hs, b_vs, b_bn, b_sn, b_fs;
  int n = 0, passed = 0, total = 0;
  bit last_pe = 1'b0;
  always #5 CLK = ~CLK;
  hv_sync_generator dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .PixEn(PixEn),
    .CounterX(ax), .CounterY(ay), .inDisplayArea(a_ida),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn), .FrameStart(a_fs)
  );
  hv_sync_generator #(
    .CNTR_WIDTH_H(5), .CNTR_WIDTH_V(5),
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(3)
  ) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .PixEn(PixEn),
    .CounterX(bx), .CounterY(by), .inDisplayArea(b_ida),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn), .FrameStart(b_fs)
  );
  // Expected {inDisplayArea, hs, vs, blank_n, FrameStart} after k enabled cycles since reset.
  function automatic logic [4:0] esig(int k, bit lpe, int ha, int hf, int hsw, int hb,
                                      int va, int vf, int vsw, int vb, int d, bit hp, bit vp);
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    int m = k - d;
    int xm, ym;
    logic ida = (k % ht) < ha && ((k / ht) % vt) < va;
    logic fs = lpe && k > 0 && (k % (ht * vt)) == 0;
    if (m < 0) return {ida, ~hp, ~vp, 1'b0, fs};
    xm = m % ht;
    ym = (m / ht) % vt;
    return {ida, (xm >= ha + hf && xm < ha + hf + hsw) ? hp : ~hp,
            (ym >= va + vf && ym < va + vf + vsw) ? vp : ~vp, xm < ha && ym < va, fs};
  endfunction
  task automatic step(bit pe);
    PixEn = pe;
    @(posedge CLK);
    #1;
    if (RESET_N && pe) n++;
    last_pe = RESET_N && pe;
  endtask
  task automatic test_reset;
    RESET_N = 1'b0;
    repeat (3) step(1'b1);
    total++; if ({ax, ay, a_fs} !== 22'd0) $display("FAIL reset_a_pos got=%0d,%0d,%b exp=0,0,0", ax, ay, a_fs); else passed++;
    total++; if ({a_hs, a_vs, a_bn, a_sn, a_ida} !== 5'b00001) $display("FAIL reset_a_pins got=%b exp=00001", {a_hs, a_vs, a_bn, a_sn, a_ida}); else passed++;
    total++; if ({bx, by, b_fs} !== 11'd0) $display("FAIL reset_b_pos got=%0d,%0d,%b exp=0,0,0", bx, by, b_fs); else passed++;
    total++; if ({b_hs, b_vs, b_bn, b_sn} !== 4'b1100) $display("FAIL reset_b_pins got=%b exp=1100", {b_hs, b_vs, b_bn, b_sn}); else passed++;
    RESET_N = 1'b1;
    n = 0;
    last_pe = 1'b0;
  endtask
  task automatic test_random_run;
    logic [25:0] ea;
    logic [14:0] eb;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0);
      ea = {11'(n % 1040), 10'((n / 1040) % 666), esig(n, last_pe, 800, 56, 120, 64, 600, 37, 6, 23, 2, 1'b1, 1'b1)};
      eb = {5'(n % 32), 5'((n / 32) % 17), esig(n, last_pe, 20, 3, 5, 4, 10, 2, 3, 2, 3, 1'b0, 1'b0)};
      total++; if ({ax, ay, a_ida, a_hs, a_vs, a_bn, a_fs} !== ea) $display("FAIL run_a n=%0d got=%h exp=%h", n, {ax, ay, a_ida, a_hs, a_vs, a_bn, a_fs}, ea); else passed++;
      total++; if ({bx, by, b_ida, b_hs, b_vs, b_bn, b_fs} !== eb) $display("FAIL run_b n=%0d got=%h exp=%h", n, {bx, by, b_ida, b_hs, b_vs, b_bn, b_fs}, eb); else passed++;
    end
  endtask
  task automatic test_line_wrap;
    int row, first, last, cnt;
    for (int i = 0; i < 1100 && n % 1040 != 1039; i++) step(1'b1);
    total++; if (ax !== 11'd1039) $display("FAIL wrap_reach got=%0d exp=1039", ax); else passed++;
    row = (n / 1040) % 666;
    step(1'b1);
    total++; if (ax !== 11'd0 || ay !== 10'(row + 1)) $display("FAIL line_wrap got=%0d,%0d exp=0,%0d", ax, ay, row + 1); else passed++;
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 1039; i++) begin
      step(1'b1);
      if (a_hs) begin
        if (first < 0) first = int'(ax);
        last = int'(ax);
        cnt++;
      end
    end
    total++; if (first != 858 || last != 977 || cnt != 120) $display("FAIL hs_window got=%0d..%0d/%0d exp=858..977/120", first, last, cnt); else passed++;
  endtask
  task automatic test_pixen_hold;
    logic [26:0] snap;
    for (int i = 0; i < 1100 && n % 1040 != 799; i++) step(1'b1);
    total++; if (ax !== 11'd799 || ay >= 10'd600) $display("FAIL hold_reach got=%0d,%0d exp=799,<600", ax, ay); else passed++;
    snap = {ax, ay, a_ida, a_hs, a_vs, a_bn, a_fs, a_sn};
    for (int i = 0; i < 5; i++) begin
      step(1'b0);
      total++; if ({ax, ay, a_ida, a_hs, a_vs, a_bn, a_fs, a_sn} !== snap) $display("FAIL hold_frozen got=%h exp=%h", {ax, ay, a_ida, a_hs, a_vs, a_bn, a_fs, a_sn}, snap); else passed++;
    end
    step(1'b1);
    total++; if (ax !== 11'd800 || a_bn !== 1'b1 || a_ida !== 1'b0) $display("FAIL blank_x800 got=x%0d bn=%b ida=%b exp=x800 bn=1 ida=0", ax, a_bn, a_ida); else passed++;
    step(1'b0);
    total++; if (a_bn !== 1'b1) $display("FAIL blank_hold got=%b exp=1", a_bn); else passed++;
    step(1'b1);
    total++; if (ax !== 11'd801 || a_bn !== 1'b1) $display("FAIL blank_x801 got=x%0d bn=%b exp=x801 bn=1", ax, a_bn); else passed++;
    step(1'b1);
    total++; if (ax !== 11'd802 || a_bn !== 1'b0) $display("FAIL blank_x802 got=x%0d bn=%b exp=x802 bn=0", ax, a_bn); else passed++;
  endtask
  task automatic test_reset_mid;
    #2;
    RESET_N = 1'b0;
    #1;
    total++; if ({ax, ay, a_fs, a_hs, a_vs, a_bn} !== 25'd0) $display("FAIL async_rst_a got=%0d,%0d pins=%b exp=0,0 pins=0000", ax, ay, {a_fs, a_hs, a_vs, a_bn}); else passed++;
    total++; if ({bx, by, b_fs, b_hs, b_vs, b_bn} !== {10'd0, 4'b0110}) $display("FAIL async_rst_b got=%0d,%0d pins=%b exp=0,0 pins=0110", bx, by, {b_fs, b_hs, b_vs, b_bn}); else passed++;
    n = 0;
    last_pe = 1'b0;
    repeat (2) step(1'b1);
    RESET_N = 1'b1;
    total++; if (ax !== 11'd0 || ay !== 10'd0 || a_fs !== 1'b0) $display("FAIL release_pos got=%0d,%0d fs=%b exp=0,0 fs=0", ax, ay, a_fs); else passed++;
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      total++; if (ax !== 11'(n) || a_fs !== 1'b0 || b_fs !== 1'b0) $display("FAIL after_release got=x%0d fs=%b%b exp=x%0d fs=00", ax, a_fs, b_fs, n); else passed++;
    end
  endtask
  task automatic test_frame;
    int bn_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
    logic [14:0] eb;
    for (int i = 0; i < 600 && (n % 544) != 0; i++) step(1'b1);
    total++; if (bx !== 5'd0 || by !== 5'd0 || b_fs !== 1'b1) $display("FAIL frame_wrap got=%0d,%0d fs=%b exp=0,0 fs=1", bx, by, b_fs); else passed++;
    for (int i = 0; i < 544; i++) begin
      step(1'b1);
      eb = {5'(n % 32), 5'((n / 32) % 17), esig(n, last_pe, 20, 3, 5, 4, 10, 2, 3, 2, 3, 1'b0, 1'b0)};
      total++; if ({bx, by, b_ida, b_hs, b_vs, b_bn, b_fs} !== eb) $display("FAIL frame_b n=%0d got=%h exp=%h", n, {bx, by, b_ida, b_hs, b_vs, b_bn, b_fs}, eb); else passed++;
      bn_cnt += int'(b_bn);
      hs_cnt += int'(!b_hs);
      vs_cnt += int'(!b_vs);
      fs_cnt += int'(b_fs);
    end
    total++; if (bn_cnt != 200) $display("FAIL frame_blank_cnt got=%0d exp=200", bn_cnt); else passed++;
    total++; if (hs_cnt != 85 || vs_cnt != 96) $display("FAIL frame_sync_cnt got=%0d/%0d exp=85/96", hs_cnt, vs_cnt); else passed++;
    total++; if (fs_cnt != 1 || b_fs !== 1'b1) $display("FAIL frame_fs_cnt got=%0d last=%b exp=1 last=1", fs_cnt, b_fs); else passed++;
    repeat (3) begin
      step(1'b0);
      total++; if (b_fs !== 1'b0 || bx !== 5'd0 || by !== 5'd0) $display("FAIL fs_no_repeat got=%0d,%0d fs=%b exp=0,0 fs=0", bx, by, b_fs); else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_random_run();
    test_line_wrap();
    test_pixen_hold();
    test_reset_mid();
    test_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
